// File: rtl/hpm_sampler_pkg.sv
// Shared types for the HPM window sampler: alert classes, sampler FSM states
// and the number of counted event lanes.
package hpm_sampler_pkg;

  localparam int NUM_HPM = 2;

  typedef enum logic [1:0] {
    ALERT_LEG = 2'b00,
    ALERT_SBO = 2'b10,
    ALERT_HBO = 2'b11
  } alert_e;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REQ,
    WAIT
  } sampler_state_e;

endpackage

// File: rtl/hpm_event_counter.sv
// One live event-counter lane. Clear has priority over increment; clear together
// with an increment loads 1 so a same-cycle event is never dropped.
module hpm_event_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk_h,
  input  logic             rst_h,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = CNT_W'(inc_i);
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hpm_window_sampler.sv
// Counts IMISS / JMP_STALL events over fixed windows, hands each frozen snapshot
// to the detector and records the returned alert class with sticky interrupts.
module hpm_window_sampler
  import hpm_sampler_pkg::*;
#(
  parameter int WINDOW_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 64
) (
  input  logic                            clk_h,
  input  logic                            rst_h,
  input  logic                            cfg_en,
  input  logic [1:0]                      evt_i,
  output logic [NUM_HPM-1:0][CNT_W-1:0]   hpm_o,
  output logic                            enable_d_o,
  input  logic                            end_d_i,
  input  logic [1:0]                      alert_i,
  output logic [1:0]                      alert_q_o,
  output logic                            alert_valid_o,
  output logic [31:0]                     alert_cnt_o,
  output logic                            irq_o,
  input  logic                            irq_clr_i,
  output logic                            timeout_err_o
);

  localparam int WC_W = $clog2(WINDOW_CYCLES);
  localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW_CYCLES - 1);
  localparam logic [TC_W-1:0] TO_LAST  = TC_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  sampler_state_e state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [TC_W-1:0] tcnt_q, tcnt_d;
  logic [NUM_HPM-1:0][CNT_W-1:0] hpm_q, hpm_d;
  logic [1:0]  alert_q, alert_d;
  logic        alert_valid_q, alert_valid_d;
  logic [31:0] alert_cnt_q, alert_cnt_d;
  logic        irq_q, irq_d;
  logic        tout_q, tout_d;

  logic snap, capture, tmo, counting, lane_clr;
  logic [NUM_HPM-1:0] lane_inc;
  logic [NUM_HPM-1:0][CNT_W-1:0] lane_cnt;

  for (genvar g = 0; g < NUM_HPM; g++) begin : g_lane
    hpm_event_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_h (clk_h),
      .rst_h (rst_h),
      .inc_i (lane_inc[g]),
      .clr_i (lane_clr),
      .cnt_o (lane_cnt[g])
    );
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Disable overrides everything, including a snapshot or done pulse this cycle.
  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    capture = 1'b0;
    tmo     = 1'b0;
    if (!cfg_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = COUNT;
        COUNT: if (wcnt_q == WIN_LAST) begin
                 snap    = 1'b1;
                 state_d = REQ;
               end
        REQ:   state_d = WAIT;
        WAIT:  if (end_d_i) begin
                 capture = 1'b1;
                 state_d = COUNT;
               end else if (tcnt_q == TO_LAST) begin
                 tmo     = 1'b1;
                 state_d = COUNT;
               end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    enable_d_o = (state_q == REQ) && cfg_en;
    counting   = cfg_en && (state_q != IDLE);
    lane_clr   = !counting || snap;
    for (int i = 0; i < NUM_HPM; i++) lane_inc[i] = counting && evt_i[i] && !snap;

    // Windows that expire while waiting simply wrap; only COUNT issues requests.
    wcnt_d = '0;
    if (counting && !capture && !tmo)
      wcnt_d = (wcnt_q == WIN_LAST) ? '0 : wcnt_q + WC_W'(1);

    tcnt_d = '0;
    if (cfg_en && state_q == WAIT) tcnt_d = tcnt_q + TC_W'(1);

    hpm_d = hpm_q;
    if (snap)
      for (int i = 0; i < NUM_HPM; i++) hpm_d[i] = lane_cnt[i] + CNT_W'(evt_i[i]);

    alert_d       = alert_q;
    alert_valid_d = 1'b0;
    alert_cnt_d   = alert_cnt_q;
    irq_d         = irq_q && !irq_clr_i;
    tout_d        = tout_q && !irq_clr_i;
    if (capture) begin
      alert_d       = alert_i;
      alert_valid_d = 1'b1;
      if (alert_i != ALERT_LEG) begin
        alert_cnt_d = sat_inc32(alert_cnt_q);
        irq_d       = 1'b1;
      end
    end
    if (tmo) tout_d = 1'b1;
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      wcnt_q        <= '0;
      tcnt_q        <= '0;
      hpm_q         <= '0;
      alert_q       <= '0;
      alert_valid_q <= 1'b0;
      alert_cnt_q   <= '0;
      irq_q         <= 1'b0;
      tout_q        <= 1'b0;
    end else begin
      wcnt_q        <= wcnt_d;
      tcnt_q        <= tcnt_d;
      hpm_q         <= hpm_d;
      alert_q       <= alert_d;
      alert_valid_q <= alert_valid_d;
      alert_cnt_q   <= alert_cnt_d;
      irq_q         <= irq_d;
      tout_q        <= tout_d;
    end
  end

  assign hpm_o         = hpm_q;
  assign alert_q_o     = alert_q;
  assign alert_valid_o = alert_valid_q;
  assign alert_cnt_o   = alert_cnt_q;
  assign irq_o         = irq_q;
  assign timeout_err_o = tout_q;

endmodule

// File: tb/tb_hpm_window_sampler.sv
// Directed bench for hpm_window_sampler with an 8-cycle window and a 16-cycle
// handshake timeout; expected values are worked out by hand per step.
module tb_hpm_window_sampler;
  import hpm_sampler_pkg::*;

  localparam int W  = 8;
  localparam int T  = 16;
  localparam int CW = 64;

  logic clk_h = 1'b0;
  logic rst_h = 1'b0;
  logic cfg_en = 1'b0;
  logic end_d_i = 1'b0;
  logic irq_clr_i = 1'b0;
  logic [1:0] evt_i = 2'b00;
  logic [1:0] alert_i = 2'b00;
  logic [NUM_HPM-1:0][CW-1:0] hpm_o;
  logic enable_d_o, alert_valid_o, irq_o, timeout_err_o;
  logic [1:0] alert_q_o;
  logic [31:0] alert_cnt_o;

  int checks = 0;
  int errors = 0;
  int en_seen = 0;

  hpm_window_sampler #(.WINDOW_CYCLES(W), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk_h         (clk_h),
    .rst_h         (rst_h),
    .cfg_en        (cfg_en),
    .evt_i         (evt_i),
    .hpm_o         (hpm_o),
    .enable_d_o    (enable_d_o),
    .end_d_i       (end_d_i),
    .alert_i       (alert_i),
    .alert_q_o     (alert_q_o),
    .alert_valid_o (alert_valid_o),
    .alert_cnt_o   (alert_cnt_o),
    .irq_o         (irq_o),
    .irq_clr_i     (irq_clr_i),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk_h = ~clk_h;

  task automatic step();
    @(posedge clk_h);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_h);
    #1;
    chk("rst_hpm0",   64'(hpm_o[0]),        64'h0);
    chk("rst_hpm1",   64'(hpm_o[1]),        64'h0);
    chk("rst_en",     64'(enable_d_o),      64'h0);
    chk("rst_alert",  64'(alert_q_o),       64'h0);
    chk("rst_valid",  64'(alert_valid_o),   64'h0);
    chk("rst_cnt",    64'(alert_cnt_o),     64'h0);
    chk("rst_irq",    64'(irq_o),           64'h0);
    chk("rst_tout",   64'(timeout_err_o),   64'h0);
    rst_h = 1'b1;
    step();
    chk("idle_no_req", 64'(enable_d_o), 64'h0);

    // Window 1: IMISS every cycle, JMP_STALL for the first 3 cycles.
    cfg_en = 1'b1;
    step();
    for (int k = 0; k < W; k++) begin
      evt_i = {(k < 3), 1'b1};
      if (k == W - 1) chk("no_req_early", 64'(enable_d_o), 64'h0);
      step();
    end
    evt_i = 2'b00;
    chk("w1_hpm0", 64'(hpm_o[0]),   64'h8);
    chk("w1_hpm1", 64'(hpm_o[1]),   64'h3);
    chk("w1_req",  64'(enable_d_o), 64'h1);
    step();
    chk("w1_req_once", 64'(enable_d_o), 64'h0);
    end_d_i = 1'b1;
    alert_i = 2'b10;
    step();
    end_d_i = 1'b0;
    alert_i = 2'b00;
    chk("sbo_alert", 64'(alert_q_o),     64'h2);
    chk("sbo_valid", 64'(alert_valid_o), 64'h1);
    chk("sbo_cnt",   64'(alert_cnt_o),   64'h1);
    chk("sbo_irq",   64'(irq_o),         64'h1);
    step();
    chk("valid_pulse", 64'(alert_valid_o), 64'h0);
    chk("irq_sticky",  64'(irq_o),         64'h1);
    irq_clr_i = 1'b1;
    step();
    irq_clr_i = 1'b0;
    chk("irq_clr", 64'(irq_o), 64'h0);

    // Disable keeps the snapshot and alert history.
    cfg_en = 1'b0;
    step();
    chk("dis_hpm0",  64'(hpm_o[0]),    64'h8);
    chk("dis_alert", 64'(alert_q_o),   64'h2);
    chk("dis_cnt",   64'(alert_cnt_o), 64'h1);
    cfg_en = 1'b1;
    step();

    // Window 2: events on cycles 0,1 and on the snapshot cycle itself.
    for (int k = 0; k < W; k++) begin
      evt_i = (k < 2) ? 2'b01 : ((k == W - 1) ? 2'b11 : 2'b00);
      step();
    end
    evt_i = 2'b00;
    chk("edge_hpm0", 64'(hpm_o[0]),   64'h3);
    chk("edge_hpm1", 64'(hpm_o[1]),   64'h1);
    chk("edge_req",  64'(enable_d_o), 64'h1);
    step();
    evt_i = 2'b11;
    repeat (5) step();
    evt_i = 2'b00;
    chk("wait_hold0", 64'(hpm_o[0]), 64'h3);
    chk("wait_hold1", 64'(hpm_o[1]), 64'h1);
    end_d_i = 1'b1;
    alert_i = 2'b00;
    step();
    end_d_i = 1'b0;
    chk("leg_valid", 64'(alert_valid_o), 64'h1);
    chk("leg_alert", 64'(alert_q_o),     64'h0);
    chk("leg_cnt",   64'(alert_cnt_o),   64'h1);
    chk("leg_irq",   64'(irq_o),         64'h0);
    repeat (W) step();
    chk("carry_hpm0", 64'(hpm_o[0]),   64'h5);
    chk("carry_hpm1", 64'(hpm_o[1]),   64'h5);
    chk("carry_req",  64'(enable_d_o), 64'h1);

    // No done pulse: timeout after 16 WAIT cycles.
    step();
    en_seen = 0;
    repeat (T - 1) begin
      step();
      if (enable_d_o) en_seen++;
    end
    chk("tout_early", 64'(timeout_err_o), 64'h0);
    step();
    chk("tout_set",   64'(timeout_err_o), 64'h1);
    chk("tout_cnt",   64'(alert_cnt_o),   64'h1);
    chk("tout_alert", 64'(alert_q_o),     64'h0);
    chk("tout_valid", 64'(alert_valid_o), 64'h0);
    repeat (W - 1) begin
      step();
      if (enable_d_o) en_seen++;
    end
    chk("no_req_in_wait", 64'(en_seen), 64'h0);
    step();
    chk("tout_count_req", 64'(enable_d_o), 64'h1);
    chk("tout_hpm0",      64'(hpm_o[0]),   64'h0);
    irq_clr_i = 1'b1;
    step();
    irq_clr_i = 1'b0;
    chk("tout_clr", 64'(timeout_err_o), 64'h0);

    // Saturating alert counter, with a clear arriving together with the set.
    force dut.alert_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.alert_cnt_q;
    chk("preload", 64'(alert_cnt_o), 64'hFFFF_FFFF);
    irq_clr_i = 1'b1;
    end_d_i = 1'b1;
    alert_i = 2'b11;
    step();
    irq_clr_i = 1'b0;
    end_d_i = 1'b0;
    alert_i = 2'b00;
    chk("sat_cnt",   64'(alert_cnt_o),   64'hFFFF_FFFF);
    chk("set_wins",  64'(irq_o),         64'h1);
    chk("hbo_alert", 64'(alert_q_o),     64'h3);
    chk("hbo_valid", 64'(alert_valid_o), 64'h1);

    // Reset in the middle of WAIT, then a late done pulse.
    evt_i = 2'b01;
    repeat (W) step();
    evt_i = 2'b00;
    step();
    chk("pre_rst_hpm0", 64'(hpm_o[0]), 64'h8);
    rst_h = 1'b0;
    #1;
    chk("mid_rst_hpm0",  64'(hpm_o[0]),      64'h0);
    chk("mid_rst_alert", 64'(alert_q_o),     64'h0);
    chk("mid_rst_cnt",   64'(alert_cnt_o),   64'h0);
    chk("mid_rst_irq",   64'(irq_o),         64'h0);
    chk("mid_rst_en",    64'(enable_d_o),    64'h0);
    step();
    rst_h = 1'b1;
    end_d_i = 1'b1;
    alert_i = 2'b11;
    step();
    end_d_i = 1'b0;
    alert_i = 2'b00;
    chk("late_valid", 64'(alert_valid_o), 64'h0);
    chk("late_alert", 64'(alert_q_o),     64'h0);
    chk("late_cnt",   64'(alert_cnt_o),   64'h0);
    chk("late_irq",   64'(irq_o),         64'h0);
    step();
    chk("late_valid2", 64'(alert_valid_o), 64'h0);

    // Disable on the snapshot cycle: no request, no snapshot.
    cfg_en = 1'b0;
    step();
    cfg_en = 1'b1;
    step();
    evt_i = 2'b11;
    repeat (W - 1) step();
    cfg_en = 1'b0;
    step();
    evt_i = 2'b00;
    chk("dis_snap_req",  64'(enable_d_o), 64'h0);
    chk("dis_snap_hpm0", 64'(hpm_o[0]),   64'h0);
    step();
    chk("dis_snap_req2", 64'(enable_d_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
